// File: rtl/pixel_delay_line_if.sv
// pixel_delay_line_if
// Groups the sample-path signals of pixel_delay_line into one bundle.
//   i_en     sample strobe, the line advances only when high
//   i_clear  synchronous flush of the fill state
//   i_depth  requested delay D in enabled samples (clamped inside the block)
//   i_data   lane-packed input, lane k at [k*WIDTH +: WIDTH]
//   o_data   delayed data, registered, zero while not valid
//   o_valid  o_data holds a real sample D enables old
//   o_fill   enabled samples since last flush (only with PIXEL_DELAY_FILL_OUT_EN)
// Modports: master drives the inputs (producer/bench), slave is the delay line.
interface pixel_delay_line_if #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 1,
  parameter int MAX_DEPTH = 1024
);
  localparam int DW   = WIDTH * CHANNELS;
  localparam int DEPW = $clog2(MAX_DEPTH + 1);

  logic            i_en;
  logic            i_clear;
  logic [DEPW-1:0] i_depth;
  logic [DW-1:0]   i_data;
  logic [DW-1:0]   o_data;
  logic            o_valid;
`ifdef PIXEL_DELAY_FILL_OUT_EN
  logic [DEPW-1:0] o_fill;

  modport master (
    output i_en, i_clear, i_depth, i_data,
    input  o_data, o_valid, o_fill
  );

  modport slave (
    input  i_en, i_clear, i_depth, i_data,
    output o_data, o_valid, o_fill
  );
`else
  modport master (
    output i_en, i_clear, i_depth, i_data,
    input  o_data, o_valid
  );

  modport slave (
    input  i_en, i_clear, i_depth, i_data,
    output o_data, o_valid
  );
`endif
endinterface

// File: rtl/pixel_delay_line.sv
// pixel_delay_line
// Enable-gated delay line for the ORB/BRIEF pixel path: CHANNELS lanes of WIDTH bits delayed by a
// run-time depth D (1..MAX_DEPTH enabled samples), backed by one circular RAM sharing one pointer.
// Behaves like a D-stage shift register clocked by i_en: after the n-th enabled edge o_data holds
// the input of enabled edge n-D+1. D=1 bypasses the RAM and acts as a plain enabled register.
// Ports:
//   i_clk    single clock, rising edge
//   i_rst_n  synchronous active-low reset, dominates clear and enable
//   bus      pixel_delay_line_if.slave: i_en, i_clear, i_depth, i_data -> o_data, o_valid [, o_fill]
// Configuration macro PIXEL_DELAY_FILL_OUT_EN:
//   defined   - o_fill exists and mirrors the fill counter, which saturates at MAX_DEPTH
//   undefined - no o_fill; the fill counter only primes up to the current depth
module pixel_delay_line #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 1,
  parameter int MAX_DEPTH = 1024
) (
  input logic               i_clk,
  input logic               i_rst_n,
  pixel_delay_line_if.slave bus
);
  localparam int DW   = WIDTH * CHANNELS;
  localparam int AW   = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam int DEPW = $clog2(MAX_DEPTH + 1);

  localparam logic [DEPW-1:0] DEPTH_ONE   = DEPW'(1);
  localparam logic [DEPW-1:0] DEPTH_MAX   = DEPW'(MAX_DEPTH);
  localparam logic [AW:0]     MAX_DEPTH_X = (AW + 1)'(MAX_DEPTH);
  localparam logic [AW-1:0]   PTR_LAST    = AW'(MAX_DEPTH - 1);

  logic [DW-1:0]   mem_r [0:MAX_DEPTH-1];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   wr_ptr_nxt_s;
  logic [AW-1:0]   rd_addr_s;
  logic [AW:0]     lag_s;
  logic [AW:0]     ptr_ext_s;
  logic [AW:0]     rd_ext_s;
  logic [DEPW-1:0] depth_q_r;
  logic [DEPW-1:0] depth_clamp_s;
  logic            depth_chg_s;
  logic [DEPW-1:0] fill_r;
  logic [DEPW-1:0] fill_sat_s;
  logic [DEPW-1:0] fill_nxt_s;
  logic [DEPW:0]   fill_inc_s;
  logic            prime_ok_s;
  logic [DW-1:0]   rd_data_s;
  logic [DW-1:0]   o_data_r;
  logic            o_valid_r;

  // Clamp the requested depth into 1..MAX_DEPTH and detect a change against the active depth.
  always_comb begin
    depth_clamp_s = bus.i_depth;
    if (bus.i_depth == {DEPW{1'b0}}) begin
      depth_clamp_s = DEPTH_ONE;
    end else if (bus.i_depth > DEPTH_MAX) begin
      depth_clamp_s = DEPTH_MAX;
    end else begin
      depth_clamp_s = bus.i_depth;
    end
    depth_chg_s = (depth_clamp_s != depth_q_r);
  end

  // Pointer arithmetic: read address = (wr_ptr - (D-1)) mod MAX_DEPTH, computed one bit wider so a
  // non-power-of-two MAX_DEPTH wraps exactly.
  always_comb begin
    lag_s     = (AW + 1)'(depth_q_r - DEPTH_ONE);
    ptr_ext_s = {1'b0, wr_ptr_r};
    if (ptr_ext_s >= lag_s) begin
      rd_ext_s = ptr_ext_s - lag_s;
    end else begin
      rd_ext_s = ptr_ext_s + MAX_DEPTH_X - lag_s;
    end
    rd_addr_s = AW'(rd_ext_s);
    if (wr_ptr_r == PTR_LAST) begin
      wr_ptr_nxt_s = {AW{1'b0}};
    end else begin
      wr_ptr_nxt_s = wr_ptr_r + AW'(1);
    end
  end

  // Read data: at D=1 the slot being read is the one being written this edge, so take the input.
  always_comb begin
    if (depth_q_r == DEPTH_ONE) begin
      rd_data_s = bus.i_data;
    end else begin
      rd_data_s = mem_r[rd_addr_s];
    end
  end

  // Fill counter next value and priming test; the +1 is one bit wider so saturation cannot wrap.
  always_comb begin
`ifdef PIXEL_DELAY_FILL_OUT_EN
    fill_sat_s = DEPTH_MAX;
`else
    fill_sat_s = depth_q_r;
`endif
    fill_inc_s = {1'b0, fill_r} + {{DEPW{1'b0}}, 1'b1};
    if (fill_r >= fill_sat_s) begin
      fill_nxt_s = fill_sat_s;
    end else begin
      fill_nxt_s = DEPW'(fill_inc_s);
    end
    prime_ok_s = (fill_inc_s >= {1'b0, depth_q_r});
  end

  // Sample RAM: written on every enabled edge outside reset, no reset of contents.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && bus.i_en) begin
      mem_r[wr_ptr_r] <= bus.i_data;
    end
  end

  // Control and output registers: flush (clear or depth change) beats enable; outputs hold when idle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_r  <= {AW{1'b0}};
      depth_q_r <= DEPTH_ONE;
      fill_r    <= {DEPW{1'b0}};
      o_valid_r <= 1'b0;
      o_data_r  <= {DW{1'b0}};
    end else begin
      depth_q_r <= depth_clamp_s;
      if (bus.i_en) begin
        wr_ptr_r <= wr_ptr_nxt_s;
      end
      if (bus.i_clear || depth_chg_s) begin
        fill_r    <= {DEPW{1'b0}};
        o_valid_r <= 1'b0;
        o_data_r  <= {DW{1'b0}};
      end else if (bus.i_en) begin
        fill_r    <= fill_nxt_s;
        o_valid_r <= prime_ok_s;
        o_data_r  <= prime_ok_s ? rd_data_s : {DW{1'b0}};
      end
    end
  end

  assign bus.o_data  = o_data_r;
  assign bus.o_valid = o_valid_r;
`ifdef PIXEL_DELAY_FILL_OUT_EN
  assign bus.o_fill  = fill_r;
`endif

endmodule

// File: tb/tb_pixel_delay_line.sv
// Directed bench for pixel_delay_line (CHANNELS=2, WIDTH=8, MAX_DEPTH=5). A behavioural model keeps
// the history of counted samples since the last flush; each step pushes the expected output to a
// scoreboard queue, which is popped and compared one time unit after the clock edge.
module tb_pixel_delay_line;
  localparam int WIDTH     = 8;
  localparam int CHANNELS  = 2;
  localparam int MAX_DEPTH = 5;
  localparam int DW        = WIDTH * CHANNELS;
  localparam int DEPW      = $clog2(MAX_DEPTH + 1);

  typedef struct packed {
    logic            v;
    logic [DW-1:0]   d;
    logic [DEPW-1:0] f;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pixel_delay_line_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .MAX_DEPTH(MAX_DEPTH)) bus ();

  pixel_delay_line #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .MAX_DEPTH(MAX_DEPTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  exp_t          sb[$];
  logic [DW-1:0] hist[$];
  int            m_dq;
  int            m_cnt;
  int            m_fill;
  logic          m_valid;
  logic [DW-1:0] m_data;
  int            vectors = 0;
  int            errors  = 0;

  // Lane 1 carries the complement of lane 0 so lane swaps are visible.
  function automatic logic [DW-1:0] pk(input int n);
    logic [7:0] b;
    b = 8'(n);
    return {~b, b};
  endfunction

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one clock edge with the given inputs.
  task automatic model_edge(input logic rst, input logic en, input logic clr, input int depth,
                            input logic [DW-1:0] data);
    int dcl;
    if (!rst) begin
      m_dq = 1; m_cnt = 0; m_fill = 0; m_valid = 1'b0; m_data = '0;
      hist.delete();
    end else begin
      dcl = (depth == 0) ? 1 : ((depth > MAX_DEPTH) ? MAX_DEPTH : depth);
      if (clr || dcl != m_dq) begin
        hist.delete();
        m_cnt = 0; m_fill = 0; m_valid = 1'b0; m_data = '0;
      end else if (en) begin
        hist.push_back(data);
        m_cnt++;
        m_fill = (m_fill < MAX_DEPTH) ? m_fill + 1 : MAX_DEPTH;
        if (m_cnt >= m_dq) begin
          m_valid = 1'b1;
          m_data  = hist[m_cnt - m_dq];
        end else begin
          m_valid = 1'b0;
          m_data  = '0;
        end
      end
      m_dq = dcl;
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic en, input logic clr,
                      input int depth, input logic [DW-1:0] data);
    exp_t e;
    rst_n       = rst;
    bus.i_en    = en;
    bus.i_clear = clr;
    bus.i_depth = DEPW'(depth);
    bus.i_data  = data;
    model_edge(rst, en, clr, depth, data);
    sb.push_back('{v: m_valid, d: m_data, f: DEPW'(m_fill)});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    vectors++;
    assert (bus.o_valid === e.v) else begin
      errors++;
      $error("FAIL %s valid observed=%b expected=%b", tag, bus.o_valid, e.v);
    end
    vectors++;
    assert (bus.o_data === e.d) else begin
      errors++;
      $error("FAIL %s data observed=%h expected=%h", tag, bus.o_data, e.d);
    end
`ifdef PIXEL_DELAY_FILL_OUT_EN
    vectors++;
    assert (bus.o_fill === e.f) else begin
      errors++;
      $error("FAIL %s fill observed=%0d expected=%0d", tag, bus.o_fill, e.f);
    end
`endif
  endtask

  function automatic logic [DW-1:0] vbit(input logic v);
    return {{(DW-1){1'b0}}, v};
  endfunction

  initial begin
    bus.i_en = 1'b0; bus.i_clear = 1'b0; bus.i_depth = DEPW'(3); bus.i_data = '0;

    // Reset state
    step("reset0", 1'b0, 1'b0, 1'b0, 3, pk(0));
    step("reset1", 1'b0, 1'b1, 1'b0, 3, pk(1));
    check_eq("reset_data", bus.o_data, '0);

    // D=3, continuous enable; first edge loads the depth
    step("d3_load", 1'b1, 1'b0, 1'b0, 3, pk(0));
    for (int n = 0; n < 8; n++) begin
      step("d3_run", 1'b1, 1'b1, 1'b0, 3, pk(n));
      if (n == 2) begin
        check_eq("d3_first_valid", vbit(bus.o_valid), vbit(1'b1));
        check_eq("d3_first_data", bus.o_data, pk(0));
      end
    end
    check_eq("d3_last_data", bus.o_data, pk(5));

    // D=1: plain enabled register
    step("d1_load", 1'b1, 1'b0, 1'b0, 1, pk(0));
    step("d1_a5", 1'b1, 1'b1, 1'b0, 1, 16'hA5A5);
    check_eq("d1_a5_data", bus.o_data, 16'hA5A5);
    check_eq("d1_a5_valid", vbit(bus.o_valid), vbit(1'b1));
    step("d1_5a", 1'b1, 1'b1, 1'b0, 1, 16'h5A5A);
    check_eq("d1_5a_data", bus.o_data, 16'h5A5A);

    // D=4 with enable on alternate cycles; idle cycles carry junk data
    step("d4_load", 1'b1, 1'b0, 1'b0, 4, pk(0));
    for (int i = 0; i < 12; i++) begin
      step("d4_gap", 1'b1, (i % 2) == 0, 1'b0, 4, ((i % 2) == 0) ? pk(20 + i) : pk(200 + i));
      if (i == 6 || i == 7) check_eq("d4_hold_data", bus.o_data, pk(20));
    end

    // D=MAX_DEPTH across pointer wrap; entered with clear + enable on the change edge
    step("wrap_clr", 1'b1, 1'b1, 1'b1, 5, pk(99));
    for (int k = 1; k <= 12; k++) begin
      step("wrap_run", 1'b1, 1'b1, 1'b0, 5, pk(k));
      if (k >= 5) check_eq("wrap_data", bus.o_data, pk(k - 4));
    end

    // Depth change 3 -> 2 mid-stream
    step("chg_load3", 1'b1, 1'b0, 1'b0, 3, pk(0));
    for (int i = 0; i < 10; i++) step("chg_d3", 1'b1, 1'b1, 1'b0, 3, pk(40 + i));
    step("chg_edge", 1'b1, 1'b1, 1'b0, 2, pk(60));
    check_eq("chg_edge_valid", vbit(bus.o_valid), vbit(1'b0));
    check_eq("chg_edge_data", bus.o_data, '0);
    step("chg_p1", 1'b1, 1'b1, 1'b0, 2, pk(61));
    check_eq("chg_p1_valid", vbit(bus.o_valid), vbit(1'b0));
    step("chg_p2", 1'b1, 1'b1, 1'b0, 2, pk(62));
    check_eq("chg_p2_data", bus.o_data, pk(61));

    // Clamp: 0 behaves as 1; 7 (largest DEPW-bit value above MAX) behaves as MAX
    step("clamp0_load", 1'b1, 1'b0, 1'b0, 0, pk(0));
    step("clamp0_run", 1'b1, 1'b1, 1'b0, 0, pk(70));
    check_eq("clamp0_data", bus.o_data, pk(70));
    step("clamp7_load", 1'b1, 1'b0, 1'b0, 7, pk(0));
    for (int i = 0; i < 6; i++) step("clamp7_run", 1'b1, 1'b1, 1'b0, 7, pk(80 + i));
    step("clamp7_same5", 1'b1, 1'b1, 1'b0, 5, pk(90));
    check_eq("clamp7_same5_data", bus.o_data, pk(82));

    // Clear with enable on the same edge
    step("clr_edge", 1'b1, 1'b1, 1'b1, 5, pk(100));
    check_eq("clr_edge_valid", vbit(bus.o_valid), vbit(1'b0));
    for (int i = 1; i <= 5; i++) step("clr_reprime", 1'b1, 1'b1, 1'b0, 5, pk(100 + i));
    check_eq("clr_reprime_data", bus.o_data, pk(101));

    // Reset mid-stream, then resume with D=2
    step("rst_mid", 1'b0, 1'b1, 1'b0, 5, pk(110));
    check_eq("rst_mid_data", bus.o_data, '0);
    step("rst_load2", 1'b1, 1'b0, 1'b0, 2, pk(0));
    step("rst_p1", 1'b1, 1'b1, 1'b0, 2, pk(111));
    step("rst_p2", 1'b1, 1'b1, 1'b0, 2, pk(112));
    check_eq("rst_p2_data", bus.o_data, pk(111));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
